// File: rtl/crypto_job_sequencer.sv
// Host-side bus master for the crypto coprocessor: loads operands, starts the
// engine, polls its CSR and returns the result over a valid/ready port.
module crypto_job_sequencer #(
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         job_valid,
  output logic         job_ready,
  input  logic         job_op,
  input  logic         job_reseed,
  input  logic [127:0] job_data_a,
  input  logic [127:0] job_data_b,
  output logic         res_valid,
  input  logic         res_ready,
  output logic [127:0] res_data,
  output logic         res_timeout,
  output logic [15:0]  writeEnable,
  output logic [255:0] writeBus,
  output logic [3:0]   selectRead,
  input  logic [255:0] dataOut
);

  localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CntW-1:0] CntMax  = CntW'(TIMEOUT_CYCLES);
  localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT_CYCLES - 1);

  localparam logic [3:0] StIdle     = 4'd0;
  localparam logic [3:0] StWrA      = 4'd1;
  localparam logic [3:0] StWrB      = 4'd2;
  localparam logic [3:0] StWrCsr    = 4'd3;
  localparam logic [3:0] StWaitBusy = 4'd4;
  localparam logic [3:0] StClrStart = 4'd5;
  localparam logic [3:0] StWaitDone = 4'd6;
  localparam logic [3:0] StRdRes    = 4'd7;
  localparam logic [3:0] StResp     = 4'd8;
  localparam logic [3:0] StAbort    = 4'd9;

  localparam logic [15:0] WeAesPt   = 16'h0001;
  localparam logic [15:0] WeAesIv   = 16'h0002;
  localparam logic [15:0] WeAesCsr  = 16'h0008;
  localparam logic [15:0] WePrngSd  = 16'h0100;
  localparam logic [15:0] WePrngCsr = 16'h0400;

  localparam logic [1:0] StatBusy = 2'b10;
  localparam logic [1:0] StatDone = 2'b01;

  logic [3:0]      state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d, cnt_inc;
  logic            op_q, op_d;
  logic            reseed_q, reseed_d;
  logic [127:0]    data_b_q, data_b_d;
  logic [15:0]     we_q, we_d;
  logic [255:0]    bus_q, bus_d;
  logic [3:0]      sel_q, sel_d;
  logic [127:0]    res_data_q, res_data_d;
  logic            res_to_q, res_to_d;

  logic [15:0] csr_we;
  logic [3:0]  csr_sel;
  logic [3:0]  res_sel;
  logic [1:0]  status;
  logic        unused_data_hi;

  assign csr_we         = op_q ? WePrngCsr : WeAesCsr;
  assign csr_sel        = op_q ? 4'd6 : 4'd3;
  assign res_sel        = op_q ? 4'd5 : 4'd2;
  assign status         = dataOut[1:0];
  assign cnt_inc        = (cnt_q == CntMax) ? cnt_q : cnt_q + CntW'(1);
  assign unused_data_hi = ^dataOut[255:128];

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    op_d       = op_q;
    reseed_d   = reseed_q;
    data_b_d   = data_b_q;
    we_d       = '0;
    bus_d      = '0;
    sel_d      = '0;
    res_data_d = res_data_q;
    res_to_d   = res_to_q;

    case (state_q)
      StIdle: begin
        if (job_valid) begin
          op_d              = job_op;
          reseed_d          = job_reseed;
          data_b_d          = job_data_b;
          we_d              = job_op ? WePrngSd : WeAesPt;
          bus_d[127:0]      = job_data_a;
          state_d           = StWrA;
        end
      end
      StWrA: begin
        if (op_q) begin
          we_d       = WePrngCsr;
          bus_d[3:0] = {reseed_q, 3'b100};
          state_d    = StWrCsr;
        end else begin
          we_d         = WeAesIv;
          bus_d[127:0] = data_b_q;
          state_d      = StWrB;
        end
      end
      StWrB: begin
        we_d       = WeAesCsr;
        bus_d[7:0] = 8'h04;
        state_d    = StWrCsr;
      end
      StWrCsr: begin
        cnt_d   = '0;
        sel_d   = csr_sel;
        state_d = StWaitBusy;
      end
      StWaitBusy: begin
        sel_d = csr_sel;
        cnt_d = cnt_inc;
        // A done flag left over from a previous job is ignored here.
        if (status == StatBusy) begin
          we_d    = csr_we;
          sel_d   = '0;
          state_d = StClrStart;
        end else if (cnt_q >= CntLast) begin
          we_d       = csr_we;
          sel_d      = '0;
          res_data_d = '0;
          res_to_d   = 1'b1;
          state_d    = StAbort;
        end
      end
      StClrStart: begin
        cnt_d   = '0;
        sel_d   = csr_sel;
        state_d = StWaitDone;
      end
      StWaitDone: begin
        sel_d = csr_sel;
        cnt_d = cnt_inc;
        if (status == StatDone) begin
          sel_d   = res_sel;
          state_d = StRdRes;
        end else if (cnt_q >= CntLast) begin
          we_d       = csr_we;
          sel_d      = '0;
          res_data_d = '0;
          res_to_d   = 1'b1;
          state_d    = StAbort;
        end
      end
      StRdRes: begin
        res_data_d = dataOut[127:0];
        res_to_d   = 1'b0;
        state_d    = StResp;
      end
      StResp: begin
        if (res_ready) begin
          state_d = StIdle;
        end
      end
      StAbort: begin
        state_d = StResp;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      op_q       <= 1'b0;
      reseed_q   <= 1'b0;
      data_b_q   <= '0;
      we_q       <= '0;
      bus_q      <= '0;
      sel_q      <= '0;
      res_data_q <= '0;
      res_to_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      op_q       <= op_d;
      reseed_q   <= reseed_d;
      data_b_q   <= data_b_d;
      we_q       <= we_d;
      bus_q      <= bus_d;
      sel_q      <= sel_d;
      res_data_q <= res_data_d;
      res_to_q   <= res_to_d;
    end
  end

  assign job_ready   = (state_q == StIdle);
  assign res_valid   = (state_q == StResp);
  assign res_data    = res_data_q;
  assign res_timeout = res_to_q;
  assign writeEnable = we_q;
  assign writeBus    = bus_q;
  assign selectRead  = sel_q;

endmodule

// File: tb/tb_crypto_job_sequencer.sv
// Directed bench for crypto_job_sequencer with a small behavioural coprocessor
// CSR model; a second instance with a short timeout covers the abort path.
module tb_crypto_job_sequencer;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic         reset;
  logic         job_valid, job_ready, job_op, job_reseed;
  logic [127:0] job_data_a, job_data_b;
  logic         res_valid, res_ready, res_timeout;
  logic [127:0] res_data;
  logic [15:0]  writeEnable;
  logic [255:0] writeBus;
  logic [3:0]   selectRead;
  logic [255:0] dataOut;

  logic         to_job_valid, to_job_ready;
  logic         to_res_valid, to_res_ready, to_res_timeout;
  logic [127:0] to_res_data;
  logic [15:0]  to_writeEnable;
  logic [255:0] to_writeBus;
  logic [3:0]   to_selectRead;
  logic [255:0] to_dataOut;

  crypto_job_sequencer #(.TIMEOUT_CYCLES(1024)) u_dut (
    .clock(clock), .reset(reset),
    .job_valid(job_valid), .job_ready(job_ready), .job_op(job_op),
    .job_reseed(job_reseed), .job_data_a(job_data_a), .job_data_b(job_data_b),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
    .res_timeout(res_timeout), .writeEnable(writeEnable), .writeBus(writeBus),
    .selectRead(selectRead), .dataOut(dataOut)
  );

  // Coprocessor that never reports busy.
  assign to_dataOut = '0;

  crypto_job_sequencer #(.TIMEOUT_CYCLES(8)) u_to (
    .clock(clock), .reset(reset),
    .job_valid(to_job_valid), .job_ready(to_job_ready), .job_op(1'b0),
    .job_reseed(1'b0), .job_data_a(128'h5), .job_data_b(128'h6),
    .res_valid(to_res_valid), .res_ready(to_res_ready), .res_data(to_res_data),
    .res_timeout(to_res_timeout), .writeEnable(to_writeEnable), .writeBus(to_writeBus),
    .selectRead(to_selectRead), .dataOut(to_dataOut)
  );

  // Coprocessor model: status goes busy `mdl_busy` cycles after the start
  // write and done `mdl_done` cycles after that.
  logic         mdl_clr;
  logic [1:0]   mdl_pre;
  int unsigned  mdl_busy, mdl_done;
  logic         mdl_prng;
  logic [127:0] mdl_result;
  logic         running;
  int unsigned  mcnt;
  logic [1:0]   mdl_status;
  logic         start_wr;

  assign start_wr = (writeEnable[3] || writeEnable[10]) && writeBus[2];

  always @(posedge clock) begin
    if (reset || mdl_clr) begin
      running <= 1'b0;
      mcnt    <= 0;
    end else if (start_wr) begin
      running <= 1'b1;
      mcnt    <= 0;
    end else if (running) begin
      mcnt <= mcnt + 1;
    end
  end

  always_comb begin
    mdl_status = mdl_pre;
    if (running && (mcnt + 1 >= mdl_busy + mdl_done)) mdl_status = 2'b01;
    else if (running && (mcnt + 1 >= mdl_busy)) mdl_status = 2'b10;
  end

  always_comb begin
    dataOut = {{128{1'b1}}, 128'h0};
    if (selectRead == (mdl_prng ? 4'd6 : 4'd3)) dataOut[1:0] = mdl_status;
    else if (selectRead == (mdl_prng ? 4'd5 : 4'd2)) dataOut[127:0] = mdl_result;
  end

  logic [15:0]  we_log[$];
  logic [255:0] bus_log[$];
  logic [15:0]  to_we_log[$];
  logic [255:0] to_bus_log[$];
  int onehot_bad = 0;
  int hi_bad     = 0;
  int early_rd   = 0;

  always @(posedge clock) begin
    if (writeEnable != 16'h0) begin
      we_log.push_back(writeEnable);
      bus_log.push_back(writeBus);
    end
    if (to_writeEnable != 16'h0) begin
      to_we_log.push_back(to_writeEnable);
      to_bus_log.push_back(to_writeBus);
    end
    if ($countones(writeEnable) > 1 || $countones(to_writeEnable) > 1) onehot_bad <= onehot_bad + 1;
    if (writeBus[255:128] != '0 || to_writeBus[255:128] != '0) hi_bad <= hi_bad + 1;
    if (selectRead == (mdl_prng ? 4'd5 : 4'd2) && mdl_status != 2'b01) early_rd <= early_rd + 1;
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic         op;
    logic         reseed;
    logic [127:0] a;
    logic [127:0] b;
    logic [1:0]   pre;
    int unsigned  busy;
    int unsigned  done;
    logic [127:0] result;
    int unsigned  lat;
    int unsigned  hold;
    int unsigned  nw;
    logic [3:0][15:0] we;
    logic [7:0]   start;
  } vec_t;

  vec_t vecs[5];

  task automatic run_vec(input vec_t v);
    int base;
    int n;
    logic [255:0] eb;
    @(negedge clock);
    mdl_clr = 1'b1; mdl_pre = v.pre; mdl_busy = v.busy; mdl_done = v.done;
    mdl_prng = v.op; mdl_result = v.result;
    @(negedge clock);
    mdl_clr = 1'b0;
    base = we_log.size();
    chk("job_ready_idle", job_ready, 1'b1);
    job_valid = 1'b1; job_op = v.op; job_reseed = v.reseed;
    job_data_a = v.a; job_data_b = v.b;
    @(posedge clock);
    @(negedge clock);
    job_valid = 1'b0;
    chk("job_ready_busy", job_ready, 1'b0);
    n = 1;
    while (!res_valid && n < 100) begin
      @(negedge clock);
      n++;
    end
    chk("latency", n, v.lat);
    chk("res_data", res_data, v.result);
    chk("res_timeout", res_timeout, 1'b0);
    for (int h = 0; h < int'(v.hold); h++) begin
      @(negedge clock);
      chk("hold_valid", res_valid, 1'b1);
      chk("hold_data", res_data, v.result);
      chk("hold_job_ready", job_ready, 1'b0);
      chk("hold_no_write", writeEnable, 16'h0);
    end
    res_ready = 1'b1;
    @(negedge clock);
    res_ready = 1'b0;
    chk("consumed_valid", res_valid, 1'b0);
    chk("consumed_job_ready", job_ready, 1'b1);
    chk("write_count", we_log.size() - base, v.nw);
    for (int k = 0; k < int'(v.nw); k++) begin
      if (k == 0) eb = {128'h0, v.a};
      else if (k == int'(v.nw) - 1) eb = '0;
      else if (k == int'(v.nw) - 2) eb = {248'h0, v.start};
      else eb = {128'h0, v.b};
      if (base + k < we_log.size()) begin
        chk("write_strobe", we_log[base + k], v.we[k]);
        chk("write_bus", bus_log[base + k], eb);
      end
    end
  endtask

  initial begin
    int n;
    int base;
    vecs[0] = '{1'b0, 1'b0, 128'h1, 128'h2, 2'b00, 1, 18, 128'd91999, 24, 0, 4,
                {16'h0008, 16'h0008, 16'h0002, 16'h0001}, 8'h04};
    vecs[1] = '{1'b1, 1'b1, 128'hACE1, 128'hFFFF, 2'b00, 1, 18, 128'h1234_5678_9ABC, 23, 0, 3,
                {16'h0000, 16'h0400, 16'h0400, 16'h0100}, 8'h0C};
    vecs[2] = '{1'b0, 1'b0, 128'h33, 128'h44, 2'b01, 4, 6, 128'hCAFE_F00D, 15, 10, 4,
                {16'h0008, 16'h0008, 16'h0002, 16'h0001}, 8'h04};
    vecs[3] = '{1'b0, 1'b0, 128'hAA55, 128'h55AA, 2'b00, 3, 4, 128'h7777_0001, 12, 2, 4,
                {16'h0008, 16'h0008, 16'h0002, 16'h0001}, 8'h04};
    vecs[4] = '{1'b1, 1'b0, 128'hBEEF, 128'h0, 2'b00, 2, 2, 128'h4242, 8, 1, 3,
                {16'h0000, 16'h0400, 16'h0400, 16'h0100}, 8'h04};

    reset = 1'b1; job_valid = 1'b0; job_op = 1'b0; job_reseed = 1'b0;
    job_data_a = '0; job_data_b = '0; res_ready = 1'b0;
    to_job_valid = 1'b0; to_res_ready = 1'b0;
    mdl_clr = 1'b0; mdl_pre = 2'b00; mdl_busy = 1; mdl_done = 1;
    mdl_prng = 1'b0; mdl_result = '0;
    repeat (2) @(posedge clock);
    @(negedge clock);
    chk("rst_job_ready", job_ready, 1'b1);
    chk("rst_res_valid", res_valid, 1'b0);
    chk("rst_res_data", res_data, 128'h0);
    chk("rst_res_timeout", res_timeout, 1'b0);
    chk("rst_we", writeEnable, 16'h0);
    chk("rst_bus", writeBus, 256'h0);
    chk("rst_sel", selectRead, 4'h0);
    reset = 1'b0;

    for (int i = 0; i < 5; i++) run_vec(vecs[i]);

    // Reset while the engine is in WAIT_DONE.
    @(negedge clock);
    mdl_clr = 1'b1; mdl_pre = 2'b00; mdl_busy = 1; mdl_done = 18;
    mdl_prng = 1'b0; mdl_result = 128'd91999;
    @(negedge clock);
    mdl_clr = 1'b0;
    base = we_log.size();
    job_valid = 1'b1; job_op = 1'b0; job_data_a = 128'h1; job_data_b = 128'h2;
    @(posedge clock);
    @(negedge clock);
    job_valid = 1'b0;
    repeat (9) @(negedge clock);
    chk("mid_wait_sel", selectRead, 4'd3);
    chk("mid_wait_writes", we_log.size() - base, 4);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    chk("midrst_job_ready", job_ready, 1'b1);
    chk("midrst_res_valid", res_valid, 1'b0);
    chk("midrst_res_data", res_data, 128'h0);
    chk("midrst_res_timeout", res_timeout, 1'b0);
    chk("midrst_we", writeEnable, 16'h0);
    chk("midrst_bus", writeBus, 256'h0);
    chk("midrst_sel", selectRead, 4'h0);
    run_vec(vecs[0]);

    // Timeout on the short-timeout instance.
    @(negedge clock);
    base = to_we_log.size();
    to_job_valid = 1'b1;
    @(posedge clock);
    @(negedge clock);
    to_job_valid = 1'b0;
    n = 1;
    while (!to_res_valid && n < 100) begin
      @(negedge clock);
      n++;
    end
    chk("to_latency", n, 13);
    chk("to_res_timeout", to_res_timeout, 1'b1);
    chk("to_res_data", to_res_data, 128'h0);
    chk("to_write_count", to_we_log.size() - base, 4);
    if (to_we_log.size() - base >= 4) begin
      chk("to_we0", to_we_log[base], 16'h0001);
      chk("to_we1", to_we_log[base + 1], 16'h0002);
      chk("to_we2", to_we_log[base + 2], 16'h0008);
      chk("to_bus2", to_bus_log[base + 2], 256'h04);
      chk("to_we3_clear", to_we_log[base + 3], 16'h0008);
      chk("to_bus3_clear", to_bus_log[base + 3], 256'h0);
    end
    to_res_ready = 1'b1;
    @(negedge clock);
    to_res_ready = 1'b0;
    chk("to_consumed", to_res_valid, 1'b0);
    chk("to_job_ready", to_job_ready, 1'b1);

    chk("onehot_strobe", onehot_bad, 0);
    chk("bus_upper_zero", hi_bad, 0);
    chk("early_result_read", early_rd, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
